// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - shared constants and enums for the GA generation scheduler
package ga_pkg;

    localparam int GA_CHROM_W = 8;
    localparam int GA_FIT_W   = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    typedef enum logic [2:0] {
        TC_NONE    = 3'd0,
        TC_MAX_GEN = 3'd1,
        TC_STALL   = 3'd2,
        TC_ABORT   = 3'd3,
        TC_TARGET  = 3'd4
    } term_cause_t;

endpackage

// File: rtl/ga_gen_sched_if.sv
// rtl/ga_gen_sched_if.sv - evaluated chromosome pair stream into the scheduler
interface ga_gen_sched_if #(
    parameter int CHROM_W = ga_pkg::GA_CHROM_W,
    parameter int FIT_W   = ga_pkg::GA_FIT_W
) ();

    logic                      eval_valid;
    logic [CHROM_W-1:0]        chrom1;
    logic [CHROM_W-1:0]        chrom2;
    logic signed [FIT_W-1:0]   fit1;
    logic signed [FIT_W-1:0]   fit2;

    modport master (
        output eval_valid, chrom1, chrom2, fit1, fit2
    );

    modport slave (
        input eval_valid, chrom1, chrom2, fit1, fit2
    );

endinterface

// File: rtl/ga_best_tracker.sv
// rtl/ga_best_tracker.sv - best-so-far compare/register and per-generation improved flag (target compare under GA_TARGET_FIT_EN)
module ga_best_tracker
    import ga_pkg::*;
#(
    parameter int CHROM_W = GA_CHROM_W,
    parameter int FIT_W   = GA_FIT_W
`ifdef GA_TARGET_FIT_EN
    ,
    parameter logic signed [FIT_W-1:0] TARGET_FIT = '0
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    upd_en,
    input  logic                    gen_end,
    input  logic [CHROM_W-1:0]      chrom1,
    input  logic [CHROM_W-1:0]      chrom2,
    input  logic signed [FIT_W-1:0] fit1,
    input  logic signed [FIT_W-1:0] fit2,
    output logic [CHROM_W-1:0]      best,
    output logic signed [FIT_W-1:0] best_fit,
    output logic                    gen_improved,
    output logic                    target_hit
);

    localparam logic signed [FIT_W-1:0] FIT_MIN = {1'b1, {(FIT_W-1){1'b0}}};

    logic [CHROM_W-1:0]      best_q, best_d, cand;
    logic signed [FIT_W-1:0] best_fit_q, best_fit_d, cand_fit;
    logic                    improved_q, improved_d, improve_now;

    // pick the better of the pair (chrom1 wins ties) and test it strictly against the best
    always_comb begin
        if (fit2 > fit1) begin
            cand     = chrom2;
            cand_fit = fit2;
        end else begin
            cand     = chrom1;
            cand_fit = fit1;
        end
        improve_now = upd_en && (cand_fit > best_fit_q);
    end

    // next best value and the improved flag, which is consumed at each generation end
    always_comb begin
        best_d     = best_q;
        best_fit_d = best_fit_q;
        improved_d = improved_q;
        if (clear) begin
            best_d     = '0;
            best_fit_d = FIT_MIN;
            improved_d = 1'b0;
        end else begin
            if (improve_now) begin
                best_d     = cand;
                best_fit_d = cand_fit;
            end
            if (gen_end) begin
                improved_d = 1'b0;
            end else if (improve_now) begin
                improved_d = 1'b1;
            end
        end
    end

    // best registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_q     <= '0;
            best_fit_q <= '0;
            improved_q <= 1'b0;
        end else begin
            best_q     <= best_d;
            best_fit_q <= best_fit_d;
            improved_q <= improved_d;
        end
    end

    assign best         = best_q;
    assign best_fit     = best_fit_q;
    // the pair closing a generation counts towards that generation's improvement
    assign gen_improved = improved_q | improve_now;

`ifdef GA_TARGET_FIT_EN
    assign target_hit = improve_now && (cand_fit >= TARGET_FIT);
`else
    assign target_hit = 1'b0;
`endif

endmodule

// File: rtl/ga_gen_sched.sv
// rtl/ga_gen_sched.sv - GA generation scheduler: run/drain/done control, termination causes (GA_TARGET_FIT_EN adds target stop)
module ga_gen_sched
    import ga_pkg::*;
#(
    parameter int POP_SIZE     = 16,
    parameter int CHROM_W      = GA_CHROM_W,
    parameter int FIT_W        = GA_FIT_W,
    parameter int MAX_GEN      = 64,
    parameter int STALL_GEN    = 8,
    parameter int DRAIN_CYCLES = 6
`ifdef GA_TARGET_FIT_EN
    ,
    parameter logic signed [FIT_W-1:0] TARGET_FIT = '0
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    ga_gen_sched_if.slave                 ev,
    output logic                          run_en,
    output logic                          busy,
    output logic                          done,
    output logic [CHROM_W-1:0]            best,
    output logic signed [FIT_W-1:0]       best_fit,
    output logic [$clog2(MAX_GEN+1)-1:0]  gen_count,
    output logic [2:0]                    term_cause
);

    localparam int PAIR_W  = (POP_SIZE / 2 > 1) ? $clog2(POP_SIZE / 2) : 1;
    localparam int GEN_W   = $clog2(MAX_GEN + 1);
    localparam int STALL_W = $clog2(STALL_GEN + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [PAIR_W-1:0]  PAIR_LAST  = PAIR_W'(POP_SIZE / 2 - 1);
    localparam logic [GEN_W-1:0]   GEN_LIMIT  = GEN_W'(MAX_GEN);
    localparam logic [STALL_W-1:0] STALL_LIM  = STALL_W'(STALL_GEN);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    sched_state_t        state_q, state_d;
    term_cause_t         cause_q, cause_d;
    logic [PAIR_W-1:0]   pair_q, pair_d;
    logic [GEN_W-1:0]    gen_q, gen_d, gen_inc;
    logic [STALL_W-1:0]  stall_q, stall_d, stall_inc;
    logic [DRAIN_W-1:0]  drain_q, drain_d;

    logic clear, upd_en, gen_end, gen_improved, target_hit;
    logic hit_max, hit_stall;

    assign clear     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign upd_en    = (state_q == ST_RUN) && ev.eval_valid;
    assign gen_end   = upd_en && (pair_q == PAIR_LAST);
    assign gen_inc   = gen_q + GEN_W'(1);
    assign stall_inc = stall_q + STALL_W'(1);
    assign hit_max   = gen_end && (gen_inc == GEN_LIMIT);
    assign hit_stall = gen_end && !gen_improved && (stall_inc == STALL_LIM);

    ga_best_tracker #(
        .CHROM_W    (CHROM_W),
        .FIT_W      (FIT_W)
`ifdef GA_TARGET_FIT_EN
        ,
        .TARGET_FIT (TARGET_FIT)
`endif
    ) u_best (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .upd_en       (upd_en),
        .gen_end      (gen_end),
        .chrom1       (ev.chrom1),
        .chrom2       (ev.chrom2),
        .fit1         (ev.fit1),
        .fit2         (ev.fit2),
        .best         (best),
        .best_fit     (best_fit),
        .gen_improved (gen_improved),
        .target_hit   (target_hit)
    );

    // state and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cause_q <= TC_NONE;
            pair_q  <= '0;
            gen_q   <= '0;
            stall_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pair_q  <= pair_d;
            gen_q   <= gen_d;
            stall_q <= stall_d;
            drain_q <= drain_d;
        end
    end

    // next state, generation bookkeeping and prioritised termination cause
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pair_d  = pair_q;
        gen_d   = gen_q;
        stall_d = stall_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cause_d = TC_NONE;
                    pair_d  = '0;
                    gen_d   = '0;
                    stall_d = '0;
                end
            end
            ST_RUN: begin
                if (ev.eval_valid) begin
                    if (pair_q == PAIR_LAST) begin
                        pair_d  = '0;
                        gen_d   = gen_inc;
                        stall_d = gen_improved ? '0 : stall_inc;
                    end else begin
                        pair_d = pair_q + PAIR_W'(1);
                    end
                end
                if (abort || target_hit || hit_max || hit_stall) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                    if (abort) begin
                        cause_d = TC_ABORT;
                    end else if (target_hit) begin
                        cause_d = TC_TARGET;
                    end else if (hit_max) begin
                        cause_d = TC_MAX_GEN;
                    end else begin
                        cause_d = TC_STALL;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // status outputs decoded from the state
    always_comb begin
        run_en     = (state_q == ST_RUN);
        busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done       = (state_q == ST_DONE);
        gen_count  = gen_q;
        term_cause = cause_q;
    end

endmodule
